pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Merges three request sources: the load-use request from hazard detection, the branch-taken redirect from EX, and the data-memory handshake from MEM.
- Drives the per-stage pipeline-register write enables and flushes, and the PC write enable.
- Owns the multi-cycle memory-wait FSM, a wait timeout, and a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 16, width of StallCnt_o performance counter.
- WAIT_W, 8, width of memory-wait cycle counter.
- MEM_TIMEOUT, 200, wait cycles without DMemReady_i before entering ERROR; must be < 2^WAIT_W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- LoadUse_i  in  1  load-use hazard request from hazard detection.
- BranchTaken_i  in  1  branch/jump resolved taken in EX.
- DMemReq_i  in  1  MEM stage holds a valid load/store this cycle.
- DMemReady_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register write enable.
- IFIDFlush_o  out  1  IF/ID becomes bubble.
- IDEXFlush_o  out  1  ID/EX control zeroed (bubble).
- EXMEMWrite_o  out  1  ID/EX and EX/MEM write enable.
- MEMWBFlush_o  out  1  MEM/WB captures bubble.
- Error_o  out  1  memory timeout, sticky.
- StallCnt_o  out  CNT_W  saturating count of cycles with PCWrite_o=0.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset (async, rst_i=1) sets state RUN, wait counter 0, StallCnt_o 0, Error_o 0.
- While rst_i=1, outputs are forced to PCWrite_o=0, IFIDWrite_o=0, EXMEMWrite_o=0, all flushes 0.
- Outputs are combinational from state plus inputs. Decisions take effect in the same cycle, with 0 latency.
- Priority is freeze > branch > load-use > normal.
- Freeze applies in RUN when DMemReq_i=1 and DMemReady_i=0, in MEM_WAIT when DMemReady_i=0, and always in ERROR:
  - PCWrite_o=0, IFIDWrite_o=0, EXMEMWrite_o=0, MEMWBFlush_o=1.
  - IFIDFlush_o=0, IDEXFlush_o=0.
- Branch applies when BranchTaken_i=1 and no freeze:
  - PCWrite_o=1, IFIDWrite_o=1, EXMEMWrite_o=1.
  - IFIDFlush_o=1, IDEXFlush_o=1.
  - LoadUse_i is ignored, because the instruction in ID is wrong-path.
- Load-use applies when LoadUse_i=1, with no freeze and no branch:
  - PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1, EXMEMWrite_o=1.
  - The other flushes are 0.
- Normal: all write enables 1, all flushes 0.
- Transitions:
  - RUN -> MEM_WAIT on DMemReq_i and !DMemReady_i; the wait counter loads 1.
  - MEM_WAIT -> RUN on DMemReady_i. In that same cycle the pipeline advances under the branch/load-use/normal rules.
  - MEM_WAIT with !DMemReady_i increments the wait counter. When the counter equals MEM_TIMEOUT, go to ERROR.
  - ERROR is sticky until reset and drives Error_o=1.
- A DMemReady_i arriving on the timeout cycle takes precedence: go to RUN, not ERROR.
- A single-cycle access (DMemReq_i and DMemReady_i both 1 in RUN) causes no stall.
- BranchTaken_i and LoadUse_i held during a freeze are serviced on the release cycle. Stage registers are frozen, so the requests persist.
- StallCnt_o increments on each cycle with PCWrite_o=0 and rst_i=0. It saturates at 2^CNT_W-1 and does not wrap.
- Asynchronous reset mid-MEM_WAIT or in ERROR returns to RUN and clears all counters immediately.

Decomposition:
- Shared package cpu_ctrl_pkg contains:
  - the state enum (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - default constants for CNT_W, WAIT_W and MEM_TIMEOUT.
- One sub-module, sat_counter (parameter W; ports clk_i, rst_i, inc_i, clr_i, count_o), instantiated twice:
  - for StallCnt_o;
  - for the wait counter, using clr_i on RUN entry.

Test Plan:
- LoadUse_i=1 for one cycle in RUN -> PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1; StallCnt_o 0->1.
- BranchTaken_i=1 and LoadUse_i=1 together -> IFIDFlush_o=1, IDEXFlush_o=1, PCWrite_o=1; StallCnt_o unchanged.
- DMemReq_i=1 with DMemReady_i low for 3 cycles, then high -> 3 freeze cycles with MEMWBFlush_o=1, release on the 4th cycle; state back to RUN, StallCnt_o=3.
- DMemReq_i=1 with DMemReady_i never asserted, MEM_TIMEOUT=4 -> ERROR entered after 4 wait cycles; Error_o=1 stays set; asserting rst_i clears it to RUN.
- CNT_W=3 with LoadUse_i held for 10 cycles -> StallCnt_o saturates at 7.
- rst_i asserted asynchronously mid-MEM_WAIT -> immediate RUN, counters 0, Error_o=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: the stall FSM state
// encoding and default sizing constants.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_WAIT_W      = 8;
  localparam int DEF_MEM_TIMEOUT = 200;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with a synchronous clear; clear wins over increment,
// and the count holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (inc_i && (r_count != MAX)) begin
      r_count <= r_count + ONE;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges load-use, branch redirect and the
// data-memory handshake into per-stage write enables, flushes and PC write.
module pipeline_stall_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WAIT_W      = DEF_WAIT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             LoadUse_i,
  input  logic             BranchTaken_i,
  input  logic             DMemReq_i,
  input  logic             DMemReady_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXFlush_o,
  output logic             EXMEMWrite_o,
  output logic             MEMWBFlush_o,
  output logic             Error_o,
  output logic [CNT_W-1:0] StallCnt_o
);

  // The wait counter already holds MEM_TIMEOUT-1 when the last allowed wait
  // cycle is seen, so reaching the limit means comparing against one less.
  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            r_state;
  state_e            w_nextState;
  logic              w_freeze;
  logic              w_waitInc;
  logic              w_waitClr;
  logic              w_stallInc;
  logic [WAIT_W-1:0] w_waitCnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_freeze    = 1'b0;
    w_waitInc   = 1'b0;
    w_waitClr   = 1'b0;
    unique case (r_state)
      RUN: begin
        if (DMemReq_i && !DMemReady_i) begin
          w_freeze    = 1'b1;
          w_waitInc   = 1'b1;
          w_nextState = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // A ready on the timeout cycle still releases the pipeline.
        if (DMemReady_i) begin
          w_waitClr   = 1'b1;
          w_nextState = RUN;
        end else begin
          w_freeze  = 1'b1;
          w_waitInc = 1'b1;
          if (w_waitCnt == TIMEOUT_M1) begin
            w_nextState = ERROR;
          end
        end
      end
      ERROR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_nextState = RUN;
      end
    endcase
  end

  always_comb begin
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IFIDFlush_o  = 1'b0;
    IDEXFlush_o  = 1'b0;
    EXMEMWrite_o = 1'b1;
    MEMWBFlush_o = 1'b0;
    if (rst_i) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      EXMEMWrite_o = 1'b0;
    end else if (w_freeze) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      EXMEMWrite_o = 1'b0;
      MEMWBFlush_o = 1'b1;
    end else if (BranchTaken_i) begin
      IFIDFlush_o = 1'b1;
      IDEXFlush_o = 1'b1;
    end else if (LoadUse_i) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      IDEXFlush_o = 1'b1;
    end
  end

  assign Error_o    = (r_state == ERROR);
  assign w_stallInc = !PCWrite_o && !rst_i;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_stallInc),
    .clr_i   (1'b0),
    .count_o (StallCnt_o)
  );

  sat_counter #(.W(WAIT_W)) u_waitCnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_waitInc),
    .clr_i   (w_waitClr),
    .count_o (w_waitCnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller with a small stall
// counter and short memory timeout so saturation and ERROR are reachable.
module tb_pipeline_stall_controller;

  localparam int CNT_W       = 3;
  localparam int WAIT_W      = 8;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             pcw;
    logic             ifidw;
    logic             ifidf;
    logic             idexf;
    logic             exmemw;
    logic             memwbf;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             loadUse, branchTaken, dMemReq, dMemReady;
  logic             pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite, memwbFlush, errorOut;
  logic [CNT_W-1:0] stallCnt;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: 0 RUN, 1 MEM_WAIT, 2 ERROR.
  int mState = 0;
  int mWait  = 0;
  int mCnt   = 0;

  pipeline_stall_controller #(
    .CNT_W       (CNT_W),
    .WAIT_W      (WAIT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .LoadUse_i     (loadUse),
    .BranchTaken_i (branchTaken),
    .DMemReq_i     (dMemReq),
    .DMemReady_i   (dMemReady),
    .PCWrite_o     (pcWrite),
    .IFIDWrite_o   (ifidWrite),
    .IFIDFlush_o   (ifidFlush),
    .IDEXFlush_o   (idexFlush),
    .EXMEMWrite_o  (exmemWrite),
    .MEMWBFlush_o  (memwbFlush),
    .Error_o       (errorOut),
    .StallCnt_o    (stallCnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("[TB] FAIL %s.scoreboard: observed=empty expected=entry", tag);
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    cmp({tag, ".PCWrite"},    {7'd0, pcWrite},    {7'd0, e.pcw});
    cmp({tag, ".IFIDWrite"},  {7'd0, ifidWrite},  {7'd0, e.ifidw});
    cmp({tag, ".IFIDFlush"},  {7'd0, ifidFlush},  {7'd0, e.ifidf});
    cmp({tag, ".IDEXFlush"},  {7'd0, idexFlush},  {7'd0, e.idexf});
    cmp({tag, ".EXMEMWrite"}, {7'd0, exmemWrite}, {7'd0, e.exmemw});
    cmp({tag, ".MEMWBFlush"}, {7'd0, memwbFlush}, {7'd0, e.memwbf});
    cmp({tag, ".Error"},      {7'd0, errorOut},   {7'd0, e.err});
    cmp({tag, ".StallCnt"},   8'(stallCnt),       8'(e.cnt));
  endtask

  // One clock of stimulus: predict, push, sample mid-cycle, then advance the model.
  task automatic applyStimulus(input logic lu, input logic br, input logic req,
                               input logic rdy, input string tag);
    exp_t e;
    logic freeze;
    loadUse     = lu;
    branchTaken = br;
    dMemReq     = req;
    dMemReady   = rdy;
    freeze = (mState == 0 && req && !rdy) || (mState == 1 && !rdy) || (mState == 2);
    e = '0;
    e.err = (mState == 2);
    e.cnt = CNT_W'(mCnt);
    if (freeze) begin
      e.memwbf = 1'b1;
    end else if (br) begin
      e.pcw = 1'b1; e.ifidw = 1'b1; e.exmemw = 1'b1; e.ifidf = 1'b1; e.idexf = 1'b1;
    end else if (lu) begin
      e.exmemw = 1'b1; e.idexf = 1'b1;
    end else begin
      e.pcw = 1'b1; e.ifidw = 1'b1; e.exmemw = 1'b1;
    end
    sb.push_back(e);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    if (!e.pcw && mCnt < CNT_MAX) mCnt++;
    case (mState)
      0: if (req && !rdy) begin mState = 1; mWait = 1; end
      1: begin
        if (rdy) begin
          mState = 0; mWait = 0;
        end else begin
          mWait++;
          if (mWait == MEM_TIMEOUT) mState = 2;
        end
      end
      default: mState = 2;
    endcase
    #1;
  endtask

  // Raises reset mid-cycle and checks the asynchronous effect before any edge.
  task automatic doReset(input string tag);
    #2;
    rst = 1'b1;
    loadUse = 1'b0; branchTaken = 1'b0; dMemReq = 1'b0; dMemReady = 1'b0;
    #1;
    mState = 0; mWait = 0; mCnt = 0;
    sb.push_back('0);
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    loadUse = 1'b0; branchTaken = 1'b0; dMemReq = 1'b0; dMemReady = 1'b0;
    @(posedge clk);
    #1;
    doReset("reset");
    applyStimulus(0, 0, 0, 0, "normal");
    applyStimulus(1, 0, 0, 0, "loaduse");
    applyStimulus(0, 0, 0, 0, "after_loaduse");
    applyStimulus(1, 1, 0, 0, "branch_over_loaduse");
    applyStimulus(0, 0, 1, 1, "single_cycle_access");

    doReset("reset_wait");
    applyStimulus(0, 0, 1, 0, "wait1");
    applyStimulus(0, 1, 1, 0, "wait2_branch_held");
    applyStimulus(0, 1, 1, 0, "wait3_branch_held");
    applyStimulus(0, 1, 1, 1, "release_branch");
    applyStimulus(0, 0, 0, 0, "post_release");

    doReset("reset_timeout");
    for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(0, 0, 1, 0, "timeout_wait");
    applyStimulus(0, 0, 1, 1, "error_ignores_ready");
    applyStimulus(1, 1, 0, 0, "error_sticky");
    doReset("reset_from_error");
    applyStimulus(0, 0, 0, 0, "run_after_error");

    for (int i = 0; i < MEM_TIMEOUT - 1; i++) applyStimulus(0, 0, 1, 0, "pre_timeout_wait");
    applyStimulus(1, 0, 1, 1, "ready_on_timeout_cycle");
    applyStimulus(0, 0, 0, 0, "no_error_after_ready");

    doReset("reset_saturate");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, "saturate");
    applyStimulus(0, 0, 0, 0, "saturated_hold");

    doReset("reset_pre_mid_wait");
    applyStimulus(0, 0, 1, 0, "mid_wait1");
    applyStimulus(0, 0, 1, 0, "mid_wait2");
    doReset("reset_mid_wait");
    applyStimulus(0, 0, 0, 0, "run_after_mid_reset");
    for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(0, 0, 1, 0, "rewait");
    applyStimulus(0, 0, 0, 0, "error_again");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
